window_framer: RTL

WINDOW_FRAMER -- requirements
Module: window_framer

---
 rtl/window_framer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/window_framer.sv
// window_framer: cuts a continuous sample stream into frames tagged with SoP/EoP.
// Ports:
//   ipClk, ipReset           clock, synchronous active-low reset
//   ipFrameLength/Count      frame size and number of frames (0 = continuous), latched on start
//   ipStart, ipStop          run control; stop takes effect at a frame boundary
//   ipInput_*/opInput_Ready  unframed input stream
//   opOutput_*/ipOutput_Ready framed output stream, one cycle behind the input
//   opBusy, opFrameDone, opConfigError, opFramesDone  status
module window_framer #(
    parameter int Width       = 16,
    parameter int LengthWidth = 12,
    parameter int CountWidth  = 16
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic [LengthWidth-1:0] ipFrameLength,
    input  logic [CountWidth-1:0]  ipFrameCount,
    input  logic                   ipStart,
    input  logic                   ipStop,
    input  logic [Width-1:0]       ipInput_Data,
    input  logic                   ipInput_Valid,
    output logic                   opInput_Ready,
    output logic                   opOutput_SoP,
    output logic                   opOutput_EoP,
    output logic [Width-1:0]       opOutput_Data,
    input  logic                   ipOutput_Ready,
    output logic                   opOutput_Valid,
    output logic                   opBusy,
    output logic                   opFrameDone,
    output logic                   opConfigError,
    output logic [CountWidth-1:0]  opFramesDone
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    state_t state, state_n;
    logic draining, drain_n;
    logic [LengthWidth-1:0] len_q, idx;
    logic [CountWidth-1:0] count_q, frames_in, frames_done;
    logic in_ready, frame_done, config_error;
    logic out_valid, skid_valid, out_valid_n, skid_valid_n;
    // buffer entry layout: {sop, eop, data}
    logic [Width+1:0] out_word, skid_word, in_word;
    logic in_xfer, out_xfer, load_out, start_ok, idx_last, eop_in, last_frame;

    assign in_xfer    = ipInput_Valid & in_ready;
    assign out_xfer   = out_valid & ipOutput_Ready;
    assign load_out   = ~out_valid | ipOutput_Ready;
    assign start_ok   = (state == IDLE) & ipStart & ~ipStop & (ipFrameLength != '0);
    assign idx_last   = idx == len_q - 1'b1;
    assign eop_in     = in_xfer & idx_last;
    assign last_frame = (count_q != '0) & (frames_in == count_q - 1'b1);
    assign in_word    = {idx == '0, idx_last, ipInput_Data};

    // in_ready is registered as ~skid_valid, so the skid slot is always free when input is taken
    assign out_valid_n  = load_out ? (skid_valid | in_xfer) : out_valid;
    assign skid_valid_n = ~load_out & (skid_valid | in_xfer);

    always_comb begin
        state_n = state;
        drain_n = draining;
        if (state == IDLE) begin
            if (start_ok) begin
                state_n = RUN;
                drain_n = 1'b0;
            end
        end else begin
            if (state == RUN && ipStop) begin
                state_n = STOPPING;
                // already on a frame boundary: nothing more to take
                if (!in_xfer && idx == '0) drain_n = 1'b1;
            end
            if (eop_in && (last_frame || ipStop || state == STOPPING)) begin
                state_n = STOPPING;
                drain_n = 1'b1;
            end
            // leave only once the final sample has left the skid buffer
            if (drain_n && !out_valid_n && !skid_valid_n) state_n = IDLE;
        end
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state        <= IDLE;
            draining     <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            skid_valid   <= 1'b0;
            out_word     <= '0;
            skid_word    <= '0;
            frame_done   <= 1'b0;
            config_error <= 1'b0;
            len_q        <= '0;
            count_q      <= '0;
            idx          <= '0;
            frames_in    <= '0;
            frames_done  <= '0;
        end else begin
            state        <= state_n;
            draining     <= drain_n;
            in_ready     <= (state_n != IDLE) & ~drain_n & ~skid_valid_n;
            out_valid    <= out_valid_n;
            skid_valid   <= skid_valid_n;
            if (load_out & (skid_valid | in_xfer)) out_word <= skid_valid ? skid_word : in_word;
            if (~load_out & in_xfer) skid_word <= in_word;
            frame_done   <= out_xfer & out_word[Width];
            config_error <= (state == IDLE) & ipStart & ~ipStop & (ipFrameLength == '0);
            if (start_ok) begin
                len_q       <= ipFrameLength;
                count_q     <= ipFrameCount;
                idx         <= '0;
                frames_in   <= '0;
                frames_done <= '0;
            end else begin
                if (in_xfer) begin
                    idx <= idx_last ? '0 : idx + 1'b1;
                    if (idx_last) frames_in <= frames_in + 1'b1;
                end
                if (out_xfer & out_word[Width] & ~&frames_done) frames_done <= frames_done + 1'b1;
            end
        end
    end

    assign opInput_Ready  = in_ready;
    assign opOutput_Valid = out_valid;
    assign opOutput_SoP   = out_valid & out_word[Width+1];
    assign opOutput_EoP   = out_valid & out_word[Width];
    assign opOutput_Data  = out_word[Width-1:0];
    assign opBusy         = state != IDLE;
    assign opFrameDone    = frame_done;
    assign opConfigError  = config_error;
    assign opFramesDone   = frames_done;
endmodule
